// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// UART transmitter that sits on the read side of a synchronous FIFO and
// drives the board TX pin.
//
// Operation:
//   * When tx_enable is high and the FIFO is not empty, the block pops one
//     word from the FIFO.
//   * It then serialises that word as a frame, in this order:
//       - one start bit (low);
//       - DATA_WIDTH data bits, LSB first;
//       - an optional even-parity bit;
//       - STOP_BITS stop bits (high).
//   * Every serial bit lasts CLKS_PER_BIT clock cycles.
//   * A frame in progress always completes, even if tx_enable drops.
//
// Build option:
//   FIFO_UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the
//                           popped word) is sent between the last data bit
//                           and the first stop bit.
//
// Ports:
//   clk           system clock; all logic on its rising edge
//   rst           synchronous, active-high reset; aborts any frame
//   tx_enable     permits starting new frames
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    registered one-cycle pop strobe to the FIFO
//   fifo_rd_data  FIFO registered read data, valid the cycle after the pop
//   tx            serial line, idles high
//   tx_busy       high whenever the transmitter is not idle
//   tx_done       one-cycle pulse during the final cycle of the last stop bit
//
// All outputs are registered: each output flop is loaded from the
// next-state value, so outputs change on the same edge as the state.
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  fifo_rd_en_q, fifo_rd_en_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_done_q, tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic start_ok;
    logic baud_wrap;

    // A new frame may start only when we are allowed to transmit and there
    // is a word waiting. This is consulted only in IDLE and on the final
    // STOP cycle, so tx_enable changes mid-frame have no effect.
    assign start_ok  = tx_enable && !fifo_empty;

    // The baud counter reaching its last count ends the current bit period.
    assign baud_wrap = (baud_q == BAUD_LAST);

    // Next-state, counter and data-path logic.
    //
    // The baud counter runs 0..CLKS_PER_BIT-1 in every bit-timed state and
    // its wrap advances to the next bit or state. The bit counter indexes
    // data bits in DATA and is reused to count stop bits in STOP.
    //
    // Data leaves through bit 0 of the shift register, which is shifted
    // right at each data-bit boundary.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_POP;
                end
            end

            S_POP: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                shift_d = fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_rd_data;
`endif
                state_d = S_START;
            end

            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = start_ok ? S_POP : S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Every state starts its timing from zero.
        if (state_d != state_q) begin
            baud_d = '0;
        end
    end

    // Registered-output decode, computed from the next state.
    //
    // Because the outputs are decoded from the next state, each output flop
    // changes on the same edge as the state itself. tx_done is raised one
    // cycle early so that its flop is high during the final cycle of the
    // last stop bit.
    always_comb begin
        fifo_rd_en_d = (state_d == S_POP);
        tx_busy_d    = (state_d != S_IDLE);
        tx_done_d    = (state_q == S_STOP) && (bit_q == STOP_LAST) &&
                       (baud_q == BAUD_PENULT);

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    //
    // Reset is synchronous: asserting it mid-frame drops the popped word and
    // returns the line to idle-high on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            fifo_rd_en_q <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = fifo_rd_en_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;

endmodule
